// File: rtl/tick_meter_pkg.sv
// Shared types and defaults for the tick frequency meter.
package tick_meter_pkg;

  localparam int unsigned DEFAULT_GATE_CYCLES = 840;
  localparam int unsigned DEFAULT_CNT_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } meter_state_e;

endpackage

// File: rtl/tick_frequency_meter_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse for an asynchronous input.
module edge_sync (
  input  logic clock_840,
  input  logic reset_n,
  input  logic signal_in,
  output logic tick
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [2:0] fill_q;

  // fill_q withholds the pulse until prev_q holds a real sample, so a level
  // that is already high at reset release is not taken for an edge.
  always_ff @(posedge clock_840 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], signal_in};
      prev_q <= sync_q[1];
      fill_q <= {fill_q[1:0], 1'b1};
      tick   <= fill_q[2] & sync_q[1] & ~prev_q;
    end
  end

endmodule

// File: rtl/tick_frequency_meter.sv
// Counts rising edges of signal_in over a GATE_CYCLES window and compares to expected.
// Optional macro TICK_METER_TOLERANCE_EN: match accepts |count-expected| <= 1.
module tick_frequency_meter
  import tick_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clock_840,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signal_in,
  input  logic [CNT_W-1:0] expected,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             match
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ACC_MAX   = '1;

  meter_state_e      state_q, state_d;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  acc;
  logic              tick;
  logic              match_c;

  edge_sync u_sync (
    .clock_840 (clock_840),
    .reset_n   (reset_n),
    .signal_in (signal_in),
    .tick      (tick)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_MEASURE;
      ST_MEASURE: if (gate_cnt == GATE_LAST) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

`ifdef TICK_METER_TOLERANCE_EN
  logic [CNT_W:0] diff_c;

  // Absolute difference in one extra bit so the subtraction never wraps.
  always_comb begin
    if (acc >= expected) diff_c = {1'b0, acc} - {1'b0, expected};
    else                 diff_c = {1'b0, expected} - {1'b0, acc};
  end
  assign match_c = (diff_c <= (CNT_W + 1)'(1));
`else
  assign match_c = (acc == expected);
`endif

  // State register, gate counter, saturating accumulator and result outputs
  always_ff @(posedge clock_840 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      gate_cnt <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      match    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      valid   <= (state_q == ST_DONE);
      if (state_q == ST_IDLE && start) begin
        gate_cnt <= '0;
        acc      <= '0;
      end else if (state_q == ST_MEASURE) begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        if (tick && acc != ACC_MAX) acc <= acc + CNT_W'(1);
      end
      if (state_q == ST_DONE) begin
        count <= acc;
        match <= match_c;
      end
    end
  end

endmodule

// File: tb/tb_tick_frequency_meter.sv
// Directed bench for tick_frequency_meter (default build and TICK_METER_TOLERANCE_EN build).
module tb_tick_frequency_meter;

  localparam int G = 840;

`ifdef TICK_METER_TOLERANCE_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif

  logic       clock_840 = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start     = 1'b0;
  logic       signal_in = 1'b1;
  logic [9:0] expected  = '0;
  logic [3:0] expected4 = '0;
  logic       busy, valid, match;
  logic [9:0] count;
  logic       busy4, valid4, match4;
  logic [3:0] count4;

  int total = 0;
  int bad   = 0;
  int half  = 0;

  typedef struct {
    int half;
    int expv;
    int cnt;
    int m;
  } vec_t;

  vec_t vecs[8];

  tick_frequency_meter #(.GATE_CYCLES(840), .CNT_W(10)) u_dut (
    .clock_840 (clock_840),
    .reset_n   (reset_n),
    .start     (start),
    .signal_in (signal_in),
    .expected  (expected),
    .busy      (busy),
    .valid     (valid),
    .count     (count),
    .match     (match)
  );

  tick_frequency_meter #(.GATE_CYCLES(840), .CNT_W(4)) u_dut4 (
    .clock_840 (clock_840),
    .reset_n   (reset_n),
    .start     (start),
    .signal_in (signal_in),
    .expected  (expected4),
    .busy      (busy4),
    .valid     (valid4),
    .count     (count4),
    .match     (match4)
  );

  always #5 clock_840 = ~clock_840;

  // Square wave on signal_in with half-period 'half' cycles; half==0 holds the level.
  initial begin : gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock_840);
      #1;
      if (half != 0) begin
        cnt++;
        if (cnt >= half) begin
          cnt = 0;
          signal_in = ~signal_in;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    repeat (12) @(posedge clock_840);
  endtask

  // Single start pulse, wait for valid, check latency and results on both instances.
  task automatic run_window(input string name, input int exp_cnt, input int exp_m);
    int n;
    int exp4;
    n    = 0;
    exp4 = (exp_cnt > 15) ? 15 : exp_cnt;
    @(negedge clock_840);
    start = 1'b1;
    @(posedge clock_840);
    #1 start = 1'b0;
    chk({name, " busy"}, 32'(busy), 1);
    while (n < 1000 && !valid) begin
      @(posedge clock_840);
      #1;
      n++;
    end
    chk({name, " latency"}, n, G + 1);
    chk({name, " count"}, 32'(count), exp_cnt);
    chk({name, " match"}, 32'(match), exp_m);
    chk({name, " busy_at_valid"}, 32'(busy), 0);
    chk({name, " valid4"}, 32'(valid4), 1);
    chk({name, " count4"}, 32'(count4), exp4);
    @(posedge clock_840);
    #1;
    chk({name, " valid_one_shot"}, 32'(valid), 0);
  endtask

  initial begin
    int n, nvalid, first, k;
    int t[3];

    vecs[0] = '{half: 210, expv: 2,   cnt: 2,   m: 1};
    vecs[1] = '{half: 1,   expv: 420, cnt: 420, m: 1};
    vecs[2] = '{half: 420, expv: 1,   cnt: 1,   m: 1};
    vecs[3] = '{half: 210, expv: 3,   cnt: 2,   m: TOL};
    vecs[4] = '{half: 210, expv: 0,   cnt: 2,   m: 0};
    vecs[5] = '{half: 210, expv: 1,   cnt: 2,   m: TOL};
    vecs[6] = '{half: 1,   expv: 421, cnt: 420, m: TOL};
    vecs[7] = '{half: 1,   expv: 418, cnt: 420, m: 0};

    // Reset state, with signal_in already high across release
    #23;
    chk("reset busy", 32'(busy), 0);
    chk("reset valid", 32'(valid), 0);
    chk("reset count", 32'(count), 0);
    chk("reset match", 32'(match), 0);
    @(negedge clock_840);
    reset_n = 1'b1;
    run_window("high_at_release", 0, 1);

    for (int i = 0; i < 8; i++) begin
      half      = vecs[i].half;
      expected  = 10'(vecs[i].expv);
      expected4 = 4'(vecs[i].expv);
      settle();
      run_window($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].m);
    end

    // Second start at cycle 100 of the window is ignored
    half     = 210;
    expected = 10'd2;
    settle();
    @(negedge clock_840);
    start = 1'b1;
    @(posedge clock_840);
    #1 start = 1'b0;
    n = 0; nvalid = 0; first = 0;
    while (n < 1000) begin
      start = (n == 100);
      @(posedge clock_840);
      #1;
      n++;
      if (valid) begin
        nvalid++;
        if (first == 0) first = n;
      end
    end
    start = 1'b0;
    chk("restart_ignored nvalid", nvalid, 1);
    chk("restart_ignored latency", first, G + 1);
    chk("restart_ignored count", 32'(count), 2);

    // Reset at cycle 400 of the window discards it
    settle();
    @(negedge clock_840);
    start = 1'b1;
    @(posedge clock_840);
    #1 start = 1'b0;
    repeat (400) @(posedge clock_840);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 0);
    chk("midreset valid", 32'(valid), 0);
    chk("midreset count", 32'(count), 0);
    chk("midreset match", 32'(match), 0);
    @(negedge clock_840);
    reset_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clock_840);
      #1;
      if (valid) nvalid++;
    end
    chk("midreset no_valid", nvalid, 0);
    chk("midreset busy_after", 32'(busy), 0);
    settle();
    run_window("after_reset", 2, 1);

    // Start held high: back-to-back windows, 1 Hz input
    half     = 420;
    expected = 10'd1;
    settle();
    @(negedge clock_840);
    start = 1'b1;
    n = 0; k = 0;
    while (k < 3 && n < 3000) begin
      @(posedge clock_840);
      #1;
      n++;
      if (valid) begin
        t[k] = n;
        chk($sformatf("b2b count%0d", k), 32'(count), 1);
        k++;
      end
    end
    start = 1'b0;
    chk("b2b windows", k, 3);
    chk("b2b first", t[0], G + 2);
    chk("b2b gap01", t[1] - t[0], G + 2);
    chk("b2b gap12", t[2] - t[1], G + 2);
    repeat (3) @(posedge clock_840);
    #1;
    chk("b2b idle_after", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_frequency_meter.md
TICK_FREQUENCY_METER -- requirements
Module: tick_frequency_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 840, measurement window length in clock_840 cycles.
REQ-002 Parameter CNT_W, default 10, width of edge count and expected value.
REQ-003 clock_840  input  1  system clock; all state rising-edge triggered; one clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  measurement request; sampled only in IDLE.
REQ-006 signal_in  input  1  slow, asynchronous tick/clock under measurement.
REQ-007 expected  input  CNT_W  reference edge count per window; sampled in the DONE cycle.
REQ-008 busy  output  1  high in MEASURE and DONE.
REQ-009 valid  output  1  one-cycle pulse when count/match are updated.
REQ-010 count  output  CNT_W  rising edges counted in the last completed window, held until the next DONE.
REQ-011 match  output  1  comparison of count against expected, held with count.

Function
REQ-012 States: IDLE, MEASURE, DONE; 2-bit encoding from the shared package.
REQ-013 IDLE: start=1 -> MEASURE next cycle; gate counter and edge accumulator cleared on the same edge.
REQ-014 MEASURE lasts exactly GATE_CYCLES cycles; gate counter counts 0..GATE_CYCLES-1; on the cycle with value GATE_CYCLES-1 -> DONE.
REQ-015 signal_in passes through a 2-flop synchronizer, then a rising-edge detector; the detect pulse arrives 3 cycles after the input edge.
REQ-016 Accumulator increments on each detect pulse while in MEASURE; pulses in IDLE/DONE are ignored.
REQ-017 Accumulator saturates at 2^CNT_W-1; it never wraps.
REQ-018 DONE lasts 1 cycle: count <= accumulator, match updated, valid=1; then -> IDLE.
REQ-019 start while in MEASURE or DONE is ignored, with no queuing; start held high in IDLE restarts back-to-back, with exactly one IDLE cycle between windows.
REQ-020 match = (count == expected) unless modified by REQ-024.
REQ-021 A detect pulse coincident with the last MEASURE cycle is counted.

Reset
REQ-022 reset_n low, at any time including mid-window: state=IDLE; busy=0, valid=0, count=0, match=0; synchronizer, edge detector, gate counter and accumulator cleared; any partial window is discarded.
REQ-023 After reset release the edge detector does not flag an edge if signal_in is already high.

Configuration
REQ-024 Macro TICK_METER_TOLERANCE_EN defined: match=1 when |count-expected| <= 1, with the difference computed in CNT_W+1 bits, no wrap. Undefined: exact equality only.

Structure
REQ-025 Package tick_meter_pkg holds the state typedef, the default GATE_CYCLES (840) and the default CNT_W (10).
REQ-026 One sub-module, edge_sync: 2-flop synchronizer plus rising-edge pulse, same clock_840/reset_n.

Verification
REQ-027 Gate 840, signal_in period 420 cycles (2 Hz), expected=2 -> valid pulse at cycle 841 after start; count=2, match=1.
REQ-028 signal_in toggling every cycle (420 Hz), CNT_W=10 -> count=420; with CNT_W=4 -> count=15 (saturated).
REQ-029 Pulse start again at cycle 100 of MEASURE -> no restart; single valid at the end of the original window.
REQ-030 reset_n low at cycle 400 of MEASURE -> busy=0, count=0, valid never pulses; a new start then measures normally.
REQ-031 count=2, expected=3 -> match=1 with TICK_METER_TOLERANCE_EN, match=0 without; expected=0 -> match=0 in both builds.
REQ-032 start held high for 3 windows, input 1 Hz (period 840) -> three valid pulses spaced GATE_CYCLES+2 cycles apart, each with count 1.
